// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pipe_pkg
// Purpose  : Shared definitions for the 5-stage MIPS pipeline control:
//            dmem wait FSM encoding, register-zero constant and the
//            stage-control bundle driven by the stall scheduler.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } dmem_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int WAIT_CNT_W = 16;

  // Per-cycle control bundle for the pipeline registers and PC.
  typedef struct packed {
    logic pc_write;
    logic pc_redirect;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_write;
  } stage_ctl_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_scheduler_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that saturates at all-ones.
// Ports    : clk   - clock
//            clr   - synchronous clear (wins over en)
//            en    - count enable
//            count - current value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_scheduler
// Purpose  : Central stall/flush scheduler for the IF/ID/EX/MEM/WB pipeline.
//            Arbitrates dmem wait, operand hazards, control redirects and
//            imem wait; drives per-stage enables, bubble and flush; holds
//            the dmem wait FSM with timeout and two saturating counters.
// Ports    : clk, reset (sync, active-high)
//            EX/MEM/ID hazard inputs, branch/jump/jr decode, imem/dmem status
//            PC_write_o, pc_redirect_o, IFID_write_o, IFID_flush_o,
//            IDEX_write_o, IDEX_bubble_o, EXMEM_write_o, MEMWB_write_o,
//            mem_timeout_o (sticky), stall_cnt_o, flush_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_scheduler
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctl_mem_read_IDEX_i,
  input  logic             ctl_reg_write_IDEX_i,
  input  logic [4:0]       reg_dst_IDEX_i,
  input  logic             ctl_mem_read_EXMEM_i,
  input  logic [4:0]       reg_dst_EXMEM_i,
  input  logic [4:0]       reg_rs_IFID_i,
  input  logic [4:0]       reg_rt_IFID_i,
  input  logic             use_rs_IFID_i,
  input  logic             use_rt_IFID_i,
  input  logic             branch_IFID_i,
  input  logic             branch_taken_i,
  input  logic             jump_IFID_i,
  input  logic             jr_IFID_i,
  input  logic             imem_ready_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             PC_write_o,
  output logic             pc_redirect_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_write_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_write_o,
  output logic             MEMWB_write_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [WAIT_CNT_W-1:0] c_TMO = WAIT_CNT_W'(MEM_TIMEOUT);

  dmem_state_t           r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_mem_timeout;

  // jr only reads rs, so an rt match never counts for it.
  function automatic logic op_match(input logic [4:0] dst, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic use_rs,
                                    input logic use_rt, input logic is_jr);
    logic w_rs_m;
    logic w_rt_m;
    w_rs_m = use_rs && (rs == dst);
    w_rt_m = use_rt && !is_jr && (rt == dst);
    return (dst != REG_ZERO) && (w_rs_m || w_rt_m);
  endfunction

  logic w_ctl;
  logic w_match_ex;
  logic w_match_mem;
  logic w_load_use;
  logic w_ctl_alu;
  logic w_ctl_ld2;
  logic w_op_hz;
  logic w_redirect;
  logic w_tmo_hit;
  logic w_freeze;

  assign w_ctl       = branch_IFID_i | jr_IFID_i;
  assign w_match_ex  = op_match(reg_dst_IDEX_i, reg_rs_IFID_i, reg_rt_IFID_i,
                                use_rs_IFID_i, use_rt_IFID_i, jr_IFID_i);
  assign w_match_mem = op_match(reg_dst_EXMEM_i, reg_rs_IFID_i, reg_rt_IFID_i,
                                use_rs_IFID_i, use_rt_IFID_i, jr_IFID_i);
  assign w_load_use  = ctl_mem_read_IDEX_i && w_match_ex;
  assign w_ctl_alu   = w_ctl && ctl_reg_write_IDEX_i && !ctl_mem_read_IDEX_i && w_match_ex;
  assign w_ctl_ld2   = w_ctl && ctl_mem_read_EXMEM_i && w_match_mem;
  assign w_op_hz     = w_load_use | w_ctl_alu | w_ctl_ld2;
  assign w_redirect  = (branch_IFID_i && branch_taken_i) | jump_IFID_i | jr_IFID_i;
  assign w_tmo_hit   = (r_state == ST_WAIT) && (r_wait_cnt == c_TMO);
  assign w_freeze    = dmem_req_i && !dmem_ready_i && !w_tmo_hit;

  stage_ctl_t w_ctl_out;

  always_comb begin
    w_ctl_out = '{pc_write: 1'b1, pc_redirect: 1'b0, ifid_write: 1'b1,
                  ifid_flush: 1'b0, idex_write: 1'b1, idex_bubble: 1'b0,
                  exmem_write: 1'b1, memwb_write: 1'b1};
    if (reset) begin
      w_ctl_out = '{pc_write: 1'b0, pc_redirect: 1'b0, ifid_write: 1'b0,
                    ifid_flush: 1'b1, idex_write: 1'b0, idex_bubble: 1'b1,
                    exmem_write: 1'b0, memwb_write: 1'b0};
    end else if (w_freeze) begin
      w_ctl_out = '0;
    end else if (w_op_hz) begin
      // Hold PC and IF/ID, inject a bubble, let the back end drain.
      w_ctl_out.pc_write    = 1'b0;
      w_ctl_out.ifid_write  = 1'b0;
      w_ctl_out.idex_bubble = 1'b1;
    end else if (w_redirect) begin
      // Redirect beats an imem wait: the stale fetch is flushed anyway.
      w_ctl_out.pc_redirect = 1'b1;
      w_ctl_out.ifid_flush  = 1'b1;
    end else if (!imem_ready_i) begin
      w_ctl_out.pc_write    = 1'b0;
      w_ctl_out.ifid_flush  = 1'b1;
    end
  end

  assign PC_write_o    = w_ctl_out.pc_write;
  assign pc_redirect_o = w_ctl_out.pc_redirect;
  assign IFID_write_o  = w_ctl_out.ifid_write;
  assign IFID_flush_o  = w_ctl_out.ifid_flush;
  assign IDEX_write_o  = w_ctl_out.idex_write;
  assign IDEX_bubble_o = w_ctl_out.idex_bubble;
  assign EXMEM_write_o = w_ctl_out.exmem_write;
  assign MEMWB_write_o = w_ctl_out.memwb_write;
  assign mem_timeout_o = r_mem_timeout;

  // Dmem wait FSM. A ready in the same cycle as the timeout is a clean release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dmem_req_i && !dmem_ready_i) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= WAIT_CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (dmem_ready_i || !dmem_req_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (w_tmo_hit) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_CNT_W'(1);
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (!w_ctl_out.pc_write),
    .count (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .en    (w_ctl_out.ifid_flush),
    .count (flush_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_scheduler
// Purpose  : Directed self-checking bench for pipeline_stall_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr_idex, rw_idex, mr_exmem;
  logic [4:0]  dst_idex, dst_exmem, rs, rt;
  logic        use_rs, use_rt, br, taken, jmp, jr, imem_rdy, dreq, drdy;
  logic        pc_w, redir, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w, tmo;
  logic [31:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  pipeline_stall_scheduler #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ctl_mem_read_IDEX_i(mr_idex), .ctl_reg_write_IDEX_i(rw_idex),
    .reg_dst_IDEX_i(dst_idex), .ctl_mem_read_EXMEM_i(mr_exmem),
    .reg_dst_EXMEM_i(dst_exmem), .reg_rs_IFID_i(rs), .reg_rt_IFID_i(rt),
    .use_rs_IFID_i(use_rs), .use_rt_IFID_i(use_rt), .branch_IFID_i(br),
    .branch_taken_i(taken), .jump_IFID_i(jmp), .jr_IFID_i(jr),
    .imem_ready_i(imem_rdy), .dmem_req_i(dreq), .dmem_ready_i(drdy),
    .PC_write_o(pc_w), .pc_redirect_o(redir), .IFID_write_o(ifid_w),
    .IFID_flush_o(ifid_f), .IDEX_write_o(idex_w), .IDEX_bubble_o(idex_b),
    .EXMEM_write_o(exmem_w), .MEMWB_write_o(memwb_w), .mem_timeout_o(tmo),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // Packed view of the control outputs: {pc_w,redir,ifid_w,ifid_f,idex_w,idex_b,exmem_w,memwb_w}
  logic [7:0] ctl;
  assign ctl = {pc_w, redir, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_w};

  localparam logic [7:0] C_RESET  = 8'b0001_0100;
  localparam logic [7:0] C_NORMAL = 8'b1010_1011;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_STALL  = 8'b0000_1111;
  localparam logic [7:0] C_REDIR  = 8'b1111_1011;
  localparam logic [7:0] C_IWAIT  = 8'b0011_1011;

  task automatic idle();
    mr_idex = 0; rw_idex = 0; dst_idex = 0; mr_exmem = 0; dst_exmem = 0;
    rs = 0; rt = 0; use_rs = 0; use_rt = 0; br = 0; taken = 0; jmp = 0; jr = 0;
    imem_rdy = 1; dreq = 0; drdy = 0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #2;
    n_checks++;
    if (ctl !== C_RESET) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_RESET);
    end
    cyc();
    cyc();
    n_checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: stall=%0d flush=%0d tmo=%b expected 0/0/0", stall_cnt, flush_cnt, tmo);
    end
    reset = 0;
  endtask

  task automatic test_load_use();
    // lw $t0 in EX, add in ID reads $t0 as rs
    idle();
    mr_idex = 1; rw_idex = 1; dst_idex = 5'd8; rs = 5'd8; use_rs = 1; rt = 5'd9; use_rt = 1;
    #1;
    n_checks++;
    if (ctl !== C_STALL) begin
      n_fail++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_STALL);
    end
    cyc(); exp_stall++;
    n_checks++;
    if (stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
    idle();
    #1;
    n_checks++;
    if (ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL normal_ctl: got %b expected %b", ctl, C_NORMAL);
    end
    cyc();
  endtask

  task automatic test_load_branch();
    // lw $t1 in EX, beq $t1,$t2 in ID (taken): two stalls then redirect
    idle();
    mr_idex = 1; rw_idex = 1; dst_idex = 5'd9;
    rs = 5'd9; rt = 5'd10; use_rs = 1; use_rt = 1; br = 1; taken = 1;
    #1;
    n_checks++;
    if (ctl !== C_STALL) begin
      n_fail++; $display("FAIL ld_br_stall1: got %b expected %b", ctl, C_STALL);
    end
    cyc(); exp_stall++;
    mr_idex = 0; rw_idex = 0; dst_idex = 0; mr_exmem = 1; dst_exmem = 5'd9;
    #1;
    n_checks++;
    if (ctl !== C_STALL) begin
      n_fail++; $display("FAIL ld_br_stall2: got %b expected %b", ctl, C_STALL);
    end
    cyc(); exp_stall++;
    mr_exmem = 0; dst_exmem = 0;
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      n_fail++; $display("FAIL ld_br_redirect: got %b expected %b", ctl, C_REDIR);
    end
    cyc(); exp_flush++;
    n_checks++;
    if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL ld_br_cnt: stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_jr();
    // add $t2 in EX, jr $t2 in ID -> 1 stall then redirect
    idle();
    rw_idex = 1; dst_idex = 5'd10; rs = 5'd10; use_rs = 1; jr = 1;
    #1;
    n_checks++;
    if (ctl !== C_STALL) begin
      n_fail++; $display("FAIL jr_alu_stall: got %b expected %b", ctl, C_STALL);
    end
    cyc(); exp_stall++;
    rw_idex = 0; dst_idex = 0;
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      n_fail++; $display("FAIL jr_redirect: got %b expected %b", ctl, C_REDIR);
    end
    cyc(); exp_flush++;
    // jr whose rt field happens to match: no hazard
    rw_idex = 1; dst_idex = 5'd10; rs = 5'd5; rt = 5'd10; use_rt = 1;
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      n_fail++; $display("FAIL jr_rt_only: got %b expected %b", ctl, C_REDIR);
    end
    cyc(); exp_flush++;
    // Loads to r0 never create a hazard
    idle();
    mr_idex = 1; rw_idex = 1; dst_idex = 5'd0; rs = 5'd0; use_rs = 1;
    #1;
    n_checks++;
    if (ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL r0_no_hazard: got %b expected %b", ctl, C_NORMAL);
    end
    cyc();
    // ALU result feeding a plain add does not stall (forwarding covers it)
    idle();
    rw_idex = 1; dst_idex = 5'd11; rs = 5'd11; use_rs = 1;
    #1;
    n_checks++;
    if (ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL alu_add_no_stall: got %b expected %b", ctl, C_NORMAL);
    end
    cyc();
    n_checks++;
    if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL jr_cnt: stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_dmem_wait();
    idle();
    dreq = 1; drdy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_FREEZE) begin
        n_fail++; $display("FAIL dmem_freeze%0d: got %b expected %b", i, ctl, C_FREEZE);
      end
      cyc(); exp_stall++;
    end
    drdy = 1;
    #1;
    n_checks++;
    if (ctl !== C_NORMAL) begin
      n_fail++; $display("FAIL dmem_release: got %b expected %b", ctl, C_NORMAL);
    end
    cyc();
    idle();
    n_checks++;
    if (tmo !== 1'b0 || stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL dmem_wait_state: tmo=%b stall=%0d expected 0/%0d", tmo, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_dmem_timeout();
    idle();
    dreq = 1; drdy = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ctl !== C_FREEZE) begin
        n_fail++; $display("FAIL tmo_freeze%0d: got %b expected %b", i, ctl, C_FREEZE);
      end
      cyc(); exp_stall++;
    end
    #1;
    n_checks++;
    if (ctl !== C_NORMAL || tmo !== 1'b0) begin
      n_fail++; $display("FAIL tmo_release: ctl=%b tmo=%b expected %b/0", ctl, tmo, C_NORMAL);
    end
    cyc();
    idle();
    n_checks++;
    if (tmo !== 1'b1) begin
      n_fail++; $display("FAIL tmo_set: got %b expected 1", tmo);
    end
    cyc(); cyc();
    n_checks++;
    if (tmo !== 1'b1 || stall_cnt !== 32'(exp_stall)) begin
      n_fail++; $display("FAIL tmo_sticky: tmo=%b stall=%0d expected 1/%0d", tmo, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_imem_wait();
    idle();
    imem_rdy = 0; br = 1; taken = 1;
    #1;
    n_checks++;
    if (ctl !== C_REDIR) begin
      n_fail++; $display("FAIL imem_redirect_wins: got %b expected %b", ctl, C_REDIR);
    end
    cyc(); exp_flush++;
    idle();
    imem_rdy = 0;
    #1;
    n_checks++;
    if (ctl !== C_IWAIT) begin
      n_fail++; $display("FAIL imem_wait: got %b expected %b", ctl, C_IWAIT);
    end
    cyc(); exp_stall++; exp_flush++;
    idle();
    n_checks++;
    if (stall_cnt !== 32'(exp_stall) || flush_cnt !== 32'(exp_flush)) begin
      n_fail++; $display("FAIL imem_cnt: stall=%0d flush=%0d expected %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_wait();
    idle();
    dreq = 1; drdy = 0;
    cyc(); cyc();
    reset = 1;
    #1;
    n_checks++;
    if (ctl !== C_RESET) begin
      n_fail++; $display("FAIL rst_wait_ctl: got %b expected %b", ctl, C_RESET);
    end
    cyc();
    reset = 0;
    idle();
    exp_stall = 0; exp_flush = 0;
    n_checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || tmo !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_clear: stall=%0d flush=%0d tmo=%b expected 0/0/0", stall_cnt, flush_cnt, tmo);
    end
    // FSM back in RUN with a cleared wait count: a fresh wait freezes 4 cycles
    dreq = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
    end
    #1;
    n_checks++;
    if (ctl !== C_NORMAL || stall_cnt !== 32'd4) begin
      n_fail++; $display("FAIL rst_wait_fsm: ctl=%b stall=%0d expected %b/4", ctl, stall_cnt, C_NORMAL);
    end
    cyc();
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_branch();
    test_jr();
    test_dmem_wait();
    test_dmem_timeout();
    test_imem_wait();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
